ram_regfile_param: RTL and testbench
====================================

Name: ram_regfile_param

Overview:
- Parametrised synchronous register-file RAM: the next generation of the 8x16 decoder/register/mux RAM.
- Adds generic WIDTH/DEPTH, an asynchronous reset, independent write and read ports, a registered read with valid flag, write-first bypass, and a sequenced bulk-clear engine with a busy flag.
- Used as local storage for datapath and lab-exercise designs.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of words (>=2; need not be a power of two).
- AW, 3, address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe, sampled at the clk rising edge.
- wr_addr  input  AW  write address.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read strobe, sampled at the clk rising edge.
- rd_addr  input  AW  read address.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  high for exactly one cycle after each accepted read.
- clr_req  input  1  request to zero the whole array.
- busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - all DEPTH words = 0; rd_data = 0; rd_valid = 0; busy = 0.
  - FSM = IDLE; clear counter = 0.
  - rst has priority over every other input.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a clk edge with clr_req=1; the counter loads 0.
  - In CLEAR, each edge writes 0 to word[counter] and increments the counter.
  - When the counter reaches DEPTH-1, that word is cleared and the FSM returns to IDLE on the same edge.
  - busy = (state == CLEAR), registered.
  - A clear takes exactly DEPTH cycles. busy goes high the edge after clr_req and falls DEPTH edges later.
- Write, IDLE only:
  - At an edge with wr_en=1 and wr_addr < DEPTH, word[wr_addr] <= wr_data.
  - wr_en=0, or an out-of-range address, leaves memory unchanged.
- Read, IDLE only, latency 1:
  - At an edge with rd_en=1, rd_data <= word[rd_addr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - An out-of-range rd_addr returns 0 with rd_valid=1.
- Read-during-write to the same address on the same edge is write-first: rd_data = wr_data.
- Simultaneous write and read to different addresses are independent; both complete on the same edge.
- While busy:
  - wr_en and rd_en are ignored (rd_valid stays 0; memory receives only the clear writes).
  - clr_req is ignored, so a clear never restarts.
- clr_req in IDLE together with wr_en or rd_en: the clear takes priority and the write/read is dropped.
- Reset asserted mid-clear aborts the sequence. Memory is zeroed by the reset itself; after release the FSM is IDLE and busy = 0.
- Combinational paths: no combinational path from any input to rd_data, rd_valid or busy. All outputs are registered.

Test Plan:
- Basic write/read:
  - rst pulse, then write d=100 @ addr1 (wr_en=1).
  - Read addr1 -> rd_data=100, rd_valid=1 one cycle after rd_en; rd_valid=0 on the following cycle with rd_en=0.
- Write gated off:
  - wr_en=0, wr_data=222 @ addr1, then read addr1 -> 100.
  - Then write 1 @ addr7 and 111 @ addr0; read 7 -> 1, read 0 -> 111, read 3 -> 0.
- Write-first bypass:
  - Same edge: write 0x5A5A @ addr2 and read addr2 -> rd_data=0x5A5A next cycle.
  - Same edge, different addresses: write addr4, read addr0 -> 111.
- Bulk clear with defaults (DEPTH=8):
  - Preload addr0=111 and addr7=1, then pulse clr_req for one cycle.
  - busy high for exactly 8 cycles.
  - wr_en=1 (0xFFFF @ addr3) and rd_en during busy -> no effect, rd_valid=0.
  - After busy falls, reads of all 8 addresses -> 0.
- Reset mid-clear and asynchronous reset:
  - Start a clear and assert rst asynchronously (between edges) on cycle 3 -> busy=0, rd_valid=0, rd_data=0 immediately.
  - After release, read addr5 -> 0, and a new write/read to addr5 succeeds.
- Non-power-of-two instance (WIDTH=8, DEPTH=5, AW=3):
  - Write 0xAB @ addr6 is ignored; read addr6 -> 0 with rd_valid=1.
  - A clear takes exactly 5 busy cycles.

Source files
------------

// File: rtl/ram_regfile_param.sv
// Parametrised register-file RAM with independent write/read ports, registered
// read with valid flag, write-first bypass and a sequenced bulk-clear engine.
module ram_regfile_param #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             clr_req,
   output logic             busy
);

   localparam int            IW      = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   logic             wr_fire, rd_fire;
   logic             wr_in_range, rd_in_range;

   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_fire = 1'b0;
      rd_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else begin
               wr_fire = wr_en && wr_in_range;
               rd_fire = rd_en;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write-first: a same-edge write to the read address forwards wr_data.
   always_comb begin
      rd_valid_d = rd_fire;
      rd_data_d  = rd_data_q;
      if (rd_fire) begin
         if (!rd_in_range)
            rd_data_d = '0;
         else if (wr_fire && (wr_addr == rd_addr))
            rd_data_d = wr_data;
         else
            rd_data_d = mem_q[rd_addr[IW-1:0]];
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // NOTE: the array is reset here because asynchronous clearing of every word is part of the block's contract.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (state_q == ST_CLEAR) begin
         mem_q[cnt_q[IW-1:0]] <= '0;
      end else if (wr_fire) begin
         mem_q[wr_addr[IW-1:0]] <= wr_data;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_regfile_param.sv
// Directed, table-driven bench for ram_regfile_param: a default 16x8 instance
// and a non-power-of-two 8x5 instance.
module tb_ram_regfile_param;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        a_wr_en, a_rd_en, a_clr_req, a_rd_valid, a_busy;
   logic [2:0]  a_wr_addr, a_rd_addr;
   logic [15:0] a_wr_data, a_rd_data;

   logic        b_wr_en, b_rd_en, b_clr_req, b_rd_valid, b_busy;
   logic [2:0]  b_wr_addr, b_rd_addr;
   logic [7:0]  b_wr_data, b_rd_data;

   ram_regfile_param dut_a (
      .clk(clk), .rst(rst),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .rd_en(a_rd_en), .rd_addr(a_rd_addr),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid),
      .clr_req(a_clr_req), .busy(a_busy)
   );

   ram_regfile_param #(.WIDTH(8), .DEPTH(5), .AW(3)) dut_b (
      .clk(clk), .rst(rst),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .clr_req(b_clr_req), .busy(b_busy)
   );

   typedef struct {
      logic        wr_en;
      logic [2:0]  wr_addr;
      logic [15:0] wr_data;
      logic        rd_en;
      logic [2:0]  rd_addr;
      logic        exp_valid;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[14];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
      a_rd_en = 1'b0; a_rd_addr = '0; a_clr_req = 1'b0;
   endtask

   task automatic b_idle();
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
      b_rd_en = 1'b0; b_rd_addr = '0; b_clr_req = 1'b0;
   endtask

   task automatic a_read(input logic [2:0] addr, input logic [15:0] exp, input string name);
      a_idle();
      a_rd_en = 1'b1; a_rd_addr = addr;
      step();
      check({name, "_valid"}, 32'(a_rd_valid), 32'd1);
      check({name, "_data"}, 32'(a_rd_data), 32'(exp));
      a_idle();
   endtask

   task automatic b_read(input logic [2:0] addr, input logic [7:0] exp, input string name);
      b_idle();
      b_rd_en = 1'b1; b_rd_addr = addr;
      step();
      check({name, "_valid"}, 32'(b_rd_valid), 32'd1);
      check({name, "_data"}, 32'(b_rd_data), 32'(exp));
      b_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      int guard;

      //           wr  waddr  wdata      rd  raddr  valid  data
      vecs[0]  = '{1'b1, 3'd1, 16'd100,   1'b0, 3'd0, 1'b0, 16'd0};
      vecs[1]  = '{1'b0, 3'd0, 16'd0,     1'b1, 3'd1, 1'b1, 16'd100};
      vecs[2]  = '{1'b0, 3'd0, 16'd0,     1'b0, 3'd0, 1'b0, 16'd100};
      vecs[3]  = '{1'b0, 3'd1, 16'd222,   1'b0, 3'd0, 1'b0, 16'd100};
      vecs[4]  = '{1'b0, 3'd0, 16'd0,     1'b1, 3'd1, 1'b1, 16'd100};
      vecs[5]  = '{1'b1, 3'd7, 16'd1,     1'b0, 3'd0, 1'b0, 16'd100};
      vecs[6]  = '{1'b1, 3'd0, 16'd111,   1'b0, 3'd0, 1'b0, 16'd100};
      vecs[7]  = '{1'b0, 3'd0, 16'd0,     1'b1, 3'd7, 1'b1, 16'd1};
      vecs[8]  = '{1'b0, 3'd0, 16'd0,     1'b1, 3'd0, 1'b1, 16'd111};
      vecs[9]  = '{1'b0, 3'd0, 16'd0,     1'b1, 3'd3, 1'b1, 16'd0};
      vecs[10] = '{1'b1, 3'd2, 16'h5A5A,  1'b1, 3'd2, 1'b1, 16'h5A5A};
      vecs[11] = '{1'b1, 3'd4, 16'h4444,  1'b1, 3'd0, 1'b1, 16'd111};
      vecs[12] = '{1'b0, 3'd0, 16'd0,     1'b1, 3'd4, 1'b1, 16'h4444};
      vecs[13] = '{1'b0, 3'd0, 16'd0,     1'b1, 3'd2, 1'b1, 16'h5A5A};

      a_idle();
      b_idle();

      // Reset state, observed without any clock edge after assertion.
      #2 rst = 1'b1;
      #1;
      check("rst_a_busy",  32'(a_busy),     32'd0);
      check("rst_a_valid", 32'(a_rd_valid), 32'd0);
      check("rst_a_data",  32'(a_rd_data),  32'd0);
      check("rst_b_busy",  32'(b_busy),     32'd0);
      check("rst_b_data",  32'(b_rd_data),  32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         a_wr_en = vecs[i].wr_en; a_wr_addr = vecs[i].wr_addr; a_wr_data = vecs[i].wr_data;
         a_rd_en = vecs[i].rd_en; a_rd_addr = vecs[i].rd_addr; a_clr_req = 1'b0;
         step();
         check($sformatf("vec%0d_valid", i), 32'(a_rd_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_data", i),  32'(a_rd_data),  32'(vecs[i].exp_data));
         check($sformatf("vec%0d_busy", i),  32'(a_busy),     32'd0);
      end
      a_idle();

      // Bulk clear; the same-edge write/read is dropped and busy-time strobes are ignored.
      a_clr_req = 1'b1;
      a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'h7777;
      a_rd_en = 1'b1; a_rd_addr = 3'd0;
      step();
      check("clr_start_busy",  32'(a_busy),     32'd1);
      check("clr_start_valid", 32'(a_rd_valid), 32'd0);
      check("clr_start_data",  32'(a_rd_data),  32'h5A5A);
      busy_cnt = a_busy ? 1 : 0;
      a_wr_addr = 3'd3; a_wr_data = 16'hFFFF; a_rd_addr = 3'd3;
      guard = 0;
      while (a_busy && guard < 20) begin
         step();
         guard++;
         check("clr_busy_valid", 32'(a_rd_valid), 32'd0);
         if (a_busy) busy_cnt++;
      end
      a_idle();
      check("clr_busy_cycles", 32'(busy_cnt), 32'd8);
      check("clr_busy_fell",   32'(a_busy),   32'd0);
      for (int i = 0; i < 8; i++) a_read(3'(i), 16'd0, $sformatf("clr_rd%0d", i));

      // Asynchronous reset in the middle of a clear.
      a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'h1234;
      step();
      a_read(3'd5, 16'h1234, "pre_abort_rd5");
      a_clr_req = 1'b1;
      step();
      a_clr_req = 1'b0;
      check("abort_busy_before", 32'(a_busy), 32'd1);
      step();
      step();
      #3 rst = 1'b1;
      #1;
      check("abort_busy",  32'(a_busy),     32'd0);
      check("abort_valid", 32'(a_rd_valid), 32'd0);
      check("abort_data",  32'(a_rd_data),  32'd0);
      #2 rst = 1'b0;
      step();
      check("abort_idle_busy", 32'(a_busy), 32'd0);
      a_read(3'd5, 16'd0, "post_abort_rd5");
      a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'hBEEF;
      step();
      a_idle();
      a_read(3'd5, 16'hBEEF, "post_abort_wr5");

      // Non-power-of-two instance.
      b_wr_en = 1'b1; b_wr_addr = 3'd6; b_wr_data = 8'hAB;
      step();
      b_wr_addr = 3'd4; b_wr_data = 8'hCD;
      step();
      b_wr_addr = 3'd1; b_wr_data = 8'h11;
      step();
      b_idle();
      b_read(3'd6, 8'h00, "b_rd6");
      b_read(3'd4, 8'hCD, "b_rd4");
      b_read(3'd1, 8'h11, "b_rd1");
      b_clr_req = 1'b1;
      step();
      b_clr_req = 1'b0;
      busy_cnt = b_busy ? 1 : 0;
      guard = 0;
      while (b_busy && guard < 20) begin
         step();
         guard++;
         if (b_busy) busy_cnt++;
      end
      check("b_clr_busy_cycles", 32'(busy_cnt), 32'd5);
      b_read(3'd4, 8'h00, "b_clr_rd4");
      b_read(3'd1, 8'h00, "b_clr_rd1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
